// File: rtl/udp_parser_pkg.sv
// Shared types and widths for the UDP parser field datapath.
// Holds the accumulator FSM state, the field width and the default counter width.
package udp_parser_pkg;
    localparam int FIELD_W   = 32;
    localparam int DEF_CNT_W = 16;

    typedef enum logic {
        FIRST = 1'b0,
        ACCUM = 1'b1
    } fma_state_t;
endpackage

// File: rtl/field_max_accum_max_cal.sv
// max_cal: unsigned running-maximum comparator.
// On a tie the accumulated operand a is kept.
module max_cal
    import udp_parser_pkg::*;
#(
    parameter int W = FIELD_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = (b > a) ? b : a;
endmodule

// File: rtl/field_max_accum.sv
// Per-packet running maximum and saturating field count with a one-entry result register.
// Define FIELD_MAX_MIN_EN to add the running minimum path and the out_min port.
module field_max_accum
    import udp_parser_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FIELD_W-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIELD_W-1:0] out_max,
    output logic [CNT_W-1:0]   out_count
`ifdef FIELD_MAX_MIN_EN
    ,
    output logic [FIELD_W-1:0] out_min
`endif
);
    fma_state_t         state_q, state_d;
    logic [FIELD_W-1:0] acc_max_q, acc_max_d, out_max_q, out_max_d;
    logic [FIELD_W-1:0] cal_max, beat_max;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d, out_count_q, out_count_d, beat_cnt;
    logic               out_valid_q, out_valid_d;
    logic               accept, finish;

    max_cal #(.W(FIELD_W)) u_max_cal (
        .a (acc_max_q),
        .b (in_data),
        .y (cal_max)
    );

    // A held result blocks new beats unless it is drained in the same cycle.
    assign in_ready = rstn && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign finish   = accept && in_last;

    always_comb begin
        beat_max    = (state_q == FIRST) ? in_data : cal_max;
        beat_cnt    = (state_q == FIRST) ? CNT_W'(1) :
                      ((acc_cnt_q == {CNT_W{1'b1}}) ? acc_cnt_q : acc_cnt_q + CNT_W'(1));
        state_d     = state_q;
        acc_max_d   = acc_max_q;
        acc_cnt_d   = acc_cnt_q;
        out_max_d   = out_max_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            acc_max_d = beat_max;
            acc_cnt_d = beat_cnt;
            state_d   = in_last ? FIRST : ACCUM;
        end
        if (finish) begin
            out_max_d   = beat_max;
            out_count_d = beat_cnt;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= FIRST;
            acc_max_q   <= '0;
            acc_cnt_q   <= '0;
            out_max_q   <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_max_q   <= acc_max_d;
            acc_cnt_q   <= acc_cnt_d;
            out_max_q   <= out_max_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_count = out_count_q;

`ifdef FIELD_MAX_MIN_EN
    logic [FIELD_W-1:0] acc_min_q, acc_min_d, out_min_q, out_min_d, beat_min;

    always_comb begin
        beat_min  = (state_q == FIRST) ? in_data :
                    ((in_data < acc_min_q) ? in_data : acc_min_q);
        acc_min_d = accept ? beat_min : acc_min_q;
        out_min_d = finish ? beat_min : out_min_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_min_q <= '0;
            out_min_q <= '0;
        end else begin
            acc_min_q <= acc_min_d;
            out_min_q <= out_min_d;
        end
    end

    assign out_min = out_min_q;
`endif
endmodule

// File: tb/tb_field_max_accum.sv
// Bench for field_max_accum: directed scenarios plus random traffic against a packet-level model.
// Honours FIELD_MAX_MIN_EN to also check out_min.
module tb_field_max_accum;
    localparam int CNT_W = 16;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_max;
    logic [CNT_W-1:0] out_count;
`ifdef FIELD_MAX_MIN_EN
    logic [31:0]      out_min;
`endif

    int checks = 0;
    int failures = 0;

    field_max_accum #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_count (out_count)
`ifdef FIELD_MAX_MIN_EN
        ,
        .out_min   (out_min)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: collect accepted beats, reduce the whole packet on its last beat.
    int unsigned      pkt[$];
    logic             exp_valid = 1'b0;
    logic [31:0]      exp_max = '0;
    logic [31:0]      exp_min = '0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic             m_take;

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            pkt.delete();
            exp_valid = 1'b0;
            exp_max   = '0;
            exp_min   = '0;
            exp_cnt   = '0;
        end else begin
            m_take = in_valid && (!exp_valid || out_ready);
            if (m_take) pkt.push_back(in_data);
            if (m_take && in_last) begin
                exp_max = pkt[0];
                exp_min = pkt[0];
                foreach (pkt[i]) begin
                    if (pkt[i] > exp_max) exp_max = pkt[i];
                    if (pkt[i] < exp_min) exp_min = pkt[i];
                end
                exp_cnt   = (pkt.size() > SAT) ? CNT_W'(SAT) : CNT_W'(pkt.size());
                exp_valid = 1'b1;
                pkt.delete();
            end else if (out_ready) begin
                exp_valid = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("in_ready", in_ready, rstn && (!exp_valid || out_ready));
        chk("out_valid", out_valid, exp_valid);
        if (exp_valid || !rstn) begin
            chk("out_max", out_max, exp_max);
            chk("out_count", out_count, exp_cnt);
`ifdef FIELD_MAX_MIN_EN
            chk("out_min", out_min, exp_min);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            step();
            n++;
        end
        chk("send_accept", acc, 1);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom);
    endtask

    initial begin
        repeat (2) step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_max", out_max, 0);
        chk("rst_out_count", out_count, 0);
        rstn = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        step();

        send(5, 0); send(9, 0); send(3, 1);
        chk("p1_valid", out_valid, 1);
        chk("p1_max", out_max, 9);
        chk("p1_count", out_count, 3);
`ifdef FIELD_MAX_MIN_EN
        chk("p1_min", out_min, 3);
`endif

        send(32'hFFFF_FFFF, 1);
        chk("p2_max", out_max, 32'hFFFF_FFFF);
        chk("p2_count", out_count, 1);
        send(0, 1);
        chk("p3_max", out_max, 0);
        chk("p3_count", out_count, 1);

        send(11, 1);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 20; in_last = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_max", out_max, 11);
            chk("stall_count", out_count, 1);
            step();
        end
        out_ready = 1'b1;
        send(20, 0); send(6, 1);
        chk("p5_max", out_max, 20);
        chk("p5_count", out_count, 2);

        send(7, 0); send(7, 0); send(7, 0);
        for (int i = 0; i < SAT + 4; i++) send(1, i == SAT + 3);
        chk("sat_max", out_max, 7);
        chk("sat_count", out_count, 65535);
`ifdef FIELD_MAX_MIN_EN
        chk("sat_min", out_min, 1);
`endif

        send(10, 0); send(20, 0);
        rstn = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_max", out_max, 0);
        chk("midrst_count", out_count, 0);
        chk("midrst_in_ready", in_ready, 0);
        repeat (2) step();
        rstn = 1'b1;
        send(4, 1);
        chk("p7_max", out_max, 4);
        chk("p7_count", out_count, 1);

        send(3, 0);
        repeat (3) step();
        send(8, 1);
        chk("gap_max", out_max, 8);
        chk("gap_count", out_count, 2);
        send(15, 1);
        chk("drain_load_valid", out_valid, 1);
        chk("drain_load_max", out_max, 15);
        chk("drain_load_count", out_count, 1);

        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_last   = 1'($urandom_range(0, 4) == 0);
            in_data   = (i < 300) ? 32'($urandom_range(0, 15)) : $urandom;
            out_ready = 1'($urandom_range(0, 2) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
